aead_mac_formatter: RTL
=======================

Name: aead_mac_formatter

Overview:
- Sits downstream of chacha20_poly1305_core's cipher path and upstream of the Poly1305 MAC engine.
- Builds the RFC 8439 MAC input stream: AAD || pad16 || ciphertext || pad16 || le64(aad_len) || le64(ct_len).
- Accepts 512-bit blocks (AAD or ciphertext) and emits full 16-byte Poly1305 words over a valid/ready handshake.
- Keeps running 64-bit byte counts and appends the length word on a finish request.

Parameters:
None. Block size is 64 bytes and word size 16 bytes, both fixed by package constants.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- init  in  1  pulse: clear counters, phase, error; abort any emission
- in_valid  in  1  input block present
- in_ready  out  1  block/finish can be accepted this cycle
- in_type  in  1  0 = AAD, 1 = ciphertext
- in_bytes  in  7  valid bytes in block, 1..64
- in_data  in  512  block; byte 0 = in_data[511:504]
- finish  in  1  request length word; sampled only when in_ready=1 and in_valid=0
- out_valid  out  1  out_data valid
- out_ready  in  1  MAC engine accepts word
- out_data  out  128  MAC word; byte 0 = out_data[127:120]
- out_last  out  1  marks length word (final word of message)
- error  out  1  sticky protocol error, cleared by init/reset
- aad_len  out  64  AAD bytes accepted so far
- ct_len  out  64  ciphertext bytes accepted so far

Behaviour:
- Reset values: in_ready=1; all other outputs 0; phase=AAD; state IDLE.
- States:
  - IDLE: in_ready=1.
  - EMIT: drain the holding register.
  - LENGTH: present the length word.
- IDLE, in_valid=1 and block legal: latch in_data with bytes at index >= in_bytes zeroed. Set chunk_cnt=0 and n_chunks=ceil(in_bytes/16). Add in_bytes to aad_len or ct_len. Go to EMIT.
  - Next cycle: out_valid=1, out_data=chunk 0 (data[511:384]).
- EMIT:
  - Each out_valid&&out_ready handshake advances chunk_cnt.
  - Chunk k = data[511-128k -: 128].
  - After the handshake on chunk n_chunks-1, go to IDLE; in_ready=1 the following cycle.
  - Throughput is n_chunks+1 cycles per block when out_ready is held high.
- out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Phase: the first ciphertext block sets phase=CT.
- Illegal block: AAD in phase CT, in_bytes=0, or in_bytes>64.
  - Block is accepted (in_ready handshake completes) and dropped.
  - error=1; counters unchanged.
- Partial block (in_bytes<64) sets partial flag for its type. A further block of the same type while the flag is set is illegal and handled as above.
- IDLE, finish=1, in_valid=0: go to LENGTH.
  - out_valid=1, out_last=1, out_data={bswap64(aad_len), bswap64(ct_len)}.
  - On handshake: clear counters, phase, and partial flags; go to IDLE.
- finish together with in_valid=1: the block is processed and finish is ignored.
- Empty AAD or empty ciphertext is legal: zero words for that part, length field 0.
- Counters wrap modulo 2^64; there is no overflow flag.
- init in any state, highest priority:
  - Next cycle: IDLE, out_valid=0, counters/phase/error/flags cleared.
  - Any in-flight word is discarded.
- reset_n low mid-operation: same effect as init.

Decomposition:
- Shared package chacha20_poly1305_pkg holds:
  - state encodings FMT_IDLE/FMT_EMIT/FMT_LENGTH;
  - TYPE_AAD/TYPE_CT;
  - BLOCK_BYTES=64, WORD_BYTES=16;
  - function bswap64;
  - function byte_mask(in_bytes) returning the 512-bit keep mask.
- No sub-module. Block is one FSM plus datapath registers.

Test Plan:
- RFC 8439 2.8.2 flow: AAD 12 bytes (in_bytes=12), then CT blocks of 64 and 50 bytes, then finish, out_ready=1.
  - Required: exactly 10 words: 1 AAD, 4 + 4 CT, 1 length.
  - AAD word bytes 12..15 are 0; last CT word bytes 2..15 are 0.
  - Length word = 128'h0c00000000000000_7200000000000000 with out_last=1.
- Backpressure: out_ready toggling 1,0,0,1 during a 64-byte block.
  - out_data stable across stalls; 4 words in order; in_ready low until after the 4th handshake.
- Empty message: init then finish.
  - Single word 128'h0 with out_last=1; aad_len=ct_len=0 afterwards.
- Protocol errors:
  - CT block then AAD block → error=1, AAD block dropped, aad_len unchanged.
  - in_bytes=0 → error=1.
  - Partial CT (20 bytes) followed by another CT → error=1.
  - init → error=0.
- Abort: init asserted while the 2nd word of a 64-byte block is stalled (out_ready=0).
  - Next cycle out_valid=0, in_ready=1, counters 0; a following 16-byte AAD block emits 1 word.
- Reset mid-emission: reset_n low 1 cycle during EMIT.
  - All outputs at reset values next cycle; no spurious out_valid.

Source files
------------

// File: rtl/chacha20_poly1305_pkg.sv
// Shared types and helpers for the ChaCha20-Poly1305 datapath.
// Holds the MAC formatter state encoding, block/word sizes, block type codes,
// plus byte-swap and byte-keep-mask helpers used on 512-bit blocks.
package chacha20_poly1305_pkg;

  typedef enum logic [1:0] {
    FMT_IDLE   = 2'd0,
    FMT_EMIT   = 2'd1,
    FMT_LENGTH = 2'd2
  } fmt_state_t;

  localparam logic TYPE_AAD = 1'b0;
  localparam logic TYPE_CT  = 1'b1;

  localparam int BLOCK_BYTES = 64;
  localparam int WORD_BYTES  = 16;

  // Reverse byte order so a counter can be placed little-endian into a
  // big-endian-indexed MAC word (byte 0 in the top bits).
  function automatic logic [63:0] bswap64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = v[56-8*i +: 8];
    end
    return r;
  endfunction

  // Keep mask for a block: byte i (at bits [511-8i -: 8]) kept when i < n.
  function automatic logic [511:0] byte_mask(input logic [6:0] n);
    logic [511:0] m;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      m[511-8*i -: 8] = (i < int'(n)) ? 8'hff : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/aead_mac_formatter.sv
// Builds the Poly1305 input stream AAD || pad16 || CT || pad16 || le64(aad) || le64(ct).
// Ports: clk/reset_n (sync, active-low), init; block input in_* with finish;
// word output out_* with out_last; sticky error; running aad_len/ct_len.
// Latency: word 0 of an accepted block is valid the next cycle; n_chunks+1 cycles per block.
module aead_mac_formatter
  import chacha20_poly1305_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_type,
  input  logic [6:0]   in_bytes,
  input  logic [511:0] in_data,
  input  logic         finish,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         error,
  output logic [63:0]  aad_len,
  output logic [63:0]  ct_len
);

  fmt_state_t   state;
  logic [511:0] data_q;       // remaining chunks, next one in the top 128 bits
  logic [1:0]   chunk_cnt;
  logic [2:0]   n_chunks;
  logic         phase_ct;
  logic         aad_partial;
  logic         ct_partial;

  logic [511:0] masked;
  logic [2:0]   n_chunks_d;
  logic         bytes_bad;
  logic         order_bad;
  logic         block_ok;
  logic         is_partial;
  logic         last_chunk;

  assign masked     = in_data & byte_mask(in_bytes);
  assign n_chunks_d = 3'(({1'b0, in_bytes} + 8'(WORD_BYTES - 1)) / 8'(WORD_BYTES));
  assign bytes_bad  = (in_bytes == 7'd0) || (in_bytes > 7'(BLOCK_BYTES));
  // AAD is closed once ciphertext starts; a short block closes its own type.
  assign order_bad  = (in_type == TYPE_AAD) ? (phase_ct || aad_partial) : ct_partial;
  assign block_ok   = !bytes_bad && !order_bad;
  assign is_partial = in_bytes < 7'(BLOCK_BYTES);
  assign last_chunk = ({1'b0, chunk_cnt} == (n_chunks - 3'd1));

  always_ff @(posedge clk) begin
    if (!reset_n || init) begin
      state       <= FMT_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      data_q      <= '0;
      chunk_cnt   <= '0;
      n_chunks    <= '0;
      phase_ct    <= 1'b0;
      aad_partial <= 1'b0;
      ct_partial  <= 1'b0;
      error       <= 1'b0;
      aad_len     <= '0;
      ct_len      <= '0;
    end else begin
      case (state)
        FMT_IDLE: begin
          if (in_valid) begin
            if (!block_ok) begin
              // Consumed and dropped; stay ready for the next request.
              error <= 1'b1;
            end else begin
              out_data  <= masked[511:384];
              data_q    <= {masked[383:0], 128'd0};
              chunk_cnt <= '0;
              n_chunks  <= n_chunks_d;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              in_ready  <= 1'b0;
              state     <= FMT_EMIT;
              if (in_type == TYPE_CT) begin
                ct_len   <= ct_len + {57'd0, in_bytes};
                phase_ct <= 1'b1;
                if (is_partial) ct_partial <= 1'b1;
              end else begin
                aad_len <= aad_len + {57'd0, in_bytes};
                if (is_partial) aad_partial <= 1'b1;
              end
            end
          end else if (finish) begin
            out_data  <= {bswap64(aad_len), bswap64(ct_len)};
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            in_ready  <= 1'b0;
            state     <= FMT_LENGTH;
          end
        end

        FMT_EMIT: begin
          if (out_ready) begin
            if (last_chunk) begin
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              state     <= FMT_IDLE;
            end else begin
              chunk_cnt <= chunk_cnt + 2'd1;
              out_data  <= data_q[511:384];
              data_q    <= {data_q[383:0], 128'd0};
            end
          end
        end

        FMT_LENGTH: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            in_ready    <= 1'b1;
            aad_len     <= '0;
            ct_len      <= '0;
            phase_ct    <= 1'b0;
            aad_partial <= 1'b0;
            ct_partial  <= 1'b0;
            state       <= FMT_IDLE;
          end
        end

        default: begin
          state     <= FMT_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
